// File: rtl/lut_mem_wide.sv
// rtl/lut_mem_wide.sv - daisy-chained bus LUT memory with wide entries split into 16-bit chunks
// Multi-chunk bus accesses are made atomic through global write/read shadow registers.
module lut_mem_wide #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BASE_ADDR  = 0,
  parameter bit          READ_ONLY  = 1'b0,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           addr_i,
  input  logic [15:0]           data_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [15:0]           addr_o,
  output logic [15:0]           data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic [AW-1:0]         user_addr,
  input  logic [DATA_WIDTH-1:0] user_data_i,
  input  logic                  user_we,
  output logic [DATA_WIDTH-1:0] user_data_o
);

  localparam int unsigned N     = (DATA_WIDTH + 15) / 16;
  localparam int unsigned PW    = N * 16;
  localparam logic [31:0] LIMIT = 32'(BASE_ADDR) + 32'(DEPTH * N);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wshadow;
  logic [PW-1:0]         rshadow;

  logic [31:0]   addr_ext;
  logic [31:0]   offset;
  logic [31:0]   entry_idx;
  logic [31:0]   chunk;
  logic [AW-1:0] entry;
  logic          hit;
  logic          is_last;
  logic          user_ok;
  logic [PW-1:0] rd_word;
  logic [PW-1:0] commit_word;

  // Range check is done at 32 bits so a window ending at 0xFFFF cannot wrap to 0.
  always_comb begin
    addr_ext    = {16'd0, addr_i};
    hit         = valid_i && (addr_ext >= 32'(BASE_ADDR)) && (addr_ext < LIMIT);
    offset      = addr_ext - 32'(BASE_ADDR);
    entry_idx   = offset / N;
    chunk       = offset % N;
    entry       = AW'(entry_idx);
    is_last     = (chunk == N - 1);
    user_ok     = (32'(user_addr) < DEPTH);
    rd_word     = PW'(mem[entry]);
    commit_word = wshadow;
    commit_word[PW-1 -: 16] = data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_o      <= '0;
      data_o      <= '0;
      rw_o        <= 1'b0;
      valid_o     <= 1'b0;
      user_data_o <= '0;
      wshadow     <= '0;
      rshadow     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      addr_o      <= addr_i;
      rw_o        <= rw_i;
      valid_o     <= valid_i;
      data_o      <= data_i;
      user_data_o <= user_ok ? mem[user_addr] : '0;

      // User write first so a same-entry bus commit below takes priority.
      if (user_we && user_ok) begin
        mem[user_addr] <= user_data_i;
      end

      if (hit) begin
        if (rw_i) begin
          if (!READ_ONLY) begin
            if (is_last) begin
              mem[entry] <= commit_word[DATA_WIDTH-1:0];
            end else begin
              wshadow[chunk*16 +: 16] <= data_i;
            end
          end
        end else if (chunk == 0) begin
          data_o  <= rd_word[15:0];
          rshadow <= rd_word;
        end else begin
          data_o <= rshadow[chunk*16 +: 16];
        end
      end
    end
  end

endmodule
